demux1to16_collect: RTL and testbench
=====================================

# demux1to16_collect

Bit-addressed 1:16 demultiplexing collector: accepts single data bits tagged with a 4-bit select index and writes each into the addressed slot of a 16-bit assembly register. It is the write-side counterpart of the 16:1 bit multiplexer. Where the mux reads bit `select` out of a word, this block builds a word by placing bit `in_bit` at position `select`. A completed or flushed word is presented on a valid/ready output port, together with a mask of the slots that were written.

## Interface

**Parameters**
- `WIDTH`, default 16: output word width. Must equal 2**`SEL_W`.
- `SEL_W`, default 4: select index width.

**Ports**
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_bit` input 1: data bit to be written.
- `select` input `SEL_W`: destination slot index for `in_bit`.
- `in_valid` input 1: `in_bit`/`select` are valid.
- `in_ready` output 1: block accepts a bit this cycle.
- `in_flush` input 1: close the current partial word.
- `out` output `WIDTH`: assembled word.
- `out_mask` output `WIDTH`: slots written in `out`; bit i set means slot i was written.
- `out_valid` output 1: `out`/`out_mask` are valid.
- `out_ready` input 1: consumer takes the word.
- `dup_err` output 1: sticky duplicate-write flag. Present only with `DEMUX_DUPCHK_EN`.

## Operation

- **State machine** has two states: FILL and HOLD. Reset state is FILL.
- **Accept:** a bit is accepted when `in_valid && in_ready`.
- **FILL state:**
  - `in_ready=1`.
  - On accept, `shadow[select] <= in_bit` and `mask[select] <= 1`.
  - Slots never written read as 0.
- **Completion:** if the mask including the current accept equals all ones, copy `shadow`/`mask` to `out`/`out_mask`, clear `shadow` and `mask`, and go to HOLD.
- **Flush:** `in_flush` in FILL with a nonzero mask (after including any same-cycle accept) transfers the partial word the same way.
  - Flush with a zero mask is ignored.
  - Flush in HOLD is ignored.
- **Same-cycle accept and flush:** the accepted bit is included in the flushed word.
- **HOLD state:**
  - `in_ready=0`, `out_valid=1`.
  - `out` and `out_mask` are stable.
  - On `out_ready=1`, go to FILL.
- **Re-write of an already-written slot (no macro):** the new value overwrites; the mask is unchanged.
- **Reset outputs:** `out=0`, `out_mask=0`, `out_valid=0`, `in_ready=1`, `dup_err=0`. Internal `shadow`/`mask` are cleared and any partial word is discarded.

## Timing

- `in_ready` and `out_valid` are decoded from the registered state only. There is no combinational path from `in_valid` or `out_ready`.
- **Latency:** `out_valid` rises on the clock edge that accepts the 16th distinct slot (or the flush). The word is visible in the cycle after that accept.
- **Throughput:**
  - One bit per clock in FILL.
  - One bubble cycle per word: the HOLD cycle in which `out_ready` is sampled.
  - Minimum period for a full 16-bit word is 17 cycles.
- **Handshake:** `out_valid` remains high until a cycle with `out_ready=1`, and drops on the following edge. `out_ready` while `out_valid=0` has no effect.
- **Reset:** `rst` asserted at any point, mid-FILL or mid-HOLD, takes effect on that edge and overrides every other input.

## Configuration

- **`DEMUX_DUPCHK_EN` defined:**
  - An accept whose `select` slot is already set in `mask` is dropped: `shadow` is unchanged and the bit does not count toward completion.
  - `dup_err` is set to 1 and stays set until `rst`.
- **Not defined:** the `dup_err` port is absent and overwrite semantics apply.

## Structure

- **Shared package / header `demux_pkg`:**
  - `DEMUX_WIDTH=16`, `DEMUX_SEL_W=4`.
  - State encodings `ST_FILL=1'b0`, `ST_HOLD=1'b1`.
  - `DEMUX_FULL_MASK=16'hFFFF`.
- **Sub-module `demux1to16_dec`:** combinational decoder, `select` plus enable to a one-hot `WIDTH`-bit write strobe. It drives the per-slot write enables of `shadow` and `mask`.
- **Top level:** holds the FSM, assembly registers, output registers and the duplicate check.

## Test plan

- **In-order fill:** write the bits of 16'h3f0a at select 0..15 in consecutive cycles. Expect `out=16'h3f0a`, `out_mask=16'hFFFF`, and `out_valid=1` one cycle after the last accept; `out_ready=1` returns to FILL next cycle.
- **Reverse-order fill:** write the same data at select 15 down to 0, with `in_valid` gaps of 2 cycles. Expect an identical `out=16'h3f0a` and no early `out_valid`.
- **Partial flush:** write select 1 with 1 and select 4 with 0, then pulse `in_flush`. Expect `out=16'h0002`, `out_mask=16'h0012`. A second flush with an empty mask leaves `out_valid` at 0.
- **Backpressure:** complete a word and hold `out_ready=0` for 3 cycles. Expect `in_ready=0`, and `out`/`out_valid` stable throughout; an `in_valid` offered in HOLD is not accepted.
- **Duplicate write:** write select 6 with 1, then select 6 with 0.
  - Without the macro: final `out[6]=0`.
  - With `DEMUX_DUPCHK_EN`: `out[6]=1` and `dup_err=1`, which stays set after the word is taken.
- **Reset mid-fill:** assert `rst` after 5 accepts. Expect `out_valid=0`, `in_ready=1`, and cleared mask; a following 16 writes of 16'hA5A5 yield exactly `out=16'hA5A5`.

Source files
------------

// File: rtl/demux1to16_collect_pkg.sv
// demux_pkg: shared sizing constants and FSM state type for the 1:16
// bit-demultiplexing collector (demux1to16_collect and its decoder).
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 16;
  localparam int unsigned DEMUX_SEL_W = 4;
  localparam logic [DEMUX_WIDTH-1:0] DEMUX_FULL_MASK = 16'hFFFF;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } demux_state_e;

endpackage

// File: rtl/demux1to16_collect_if.sv
// demux1to16_collect_if: input bit stream and output word handshake.
//   Input side : in_bit, select, in_valid, in_flush (to block), in_ready (from block)
//   Output side: out, out_mask, out_valid (from block), out_ready (to block)
//   dup_err    : sticky duplicate-write flag, only when DEMUX_DUPCHK_EN is defined
// master = producer/consumer environment, slave = collector.
interface demux1to16_collect_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned SEL_W = DEMUX_SEL_W
);

  logic             in_bit;
  logic [SEL_W-1:0] select;
  logic             in_valid;
  logic             in_ready;
  logic             in_flush;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_mask;
  logic             out_valid;
  logic             out_ready;
`ifdef DEMUX_DUPCHK_EN
  logic             dup_err;
`endif

  modport master (
    output in_bit, select, in_valid, in_flush, out_ready,
    input  in_ready, out, out_mask, out_valid
`ifdef DEMUX_DUPCHK_EN
    , input dup_err
`endif
  );

  modport slave (
    input  in_bit, select, in_valid, in_flush, out_ready,
    output in_ready, out, out_mask, out_valid
`ifdef DEMUX_DUPCHK_EN
    , output dup_err
`endif
  );

endinterface

// File: rtl/demux1to16_collect_dec.sv
// demux1to16_dec: combinational select-to-one-hot write strobe.
//   sel_i    : slot index
//   en_i     : strobe enable (all zeros when low)
//   strobe_o : one-hot WIDTH-bit write enable
module demux1to16_dec
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned SEL_W = DEMUX_SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] strobe_o
);

  always_comb begin
    strobe_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (en_i && (sel_i == SEL_W'(i))) strobe_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to16_collect.sv
// demux1to16_collect: places each accepted bit at slot `select` of an
// assembly word; a full or flushed word is held on out/out_mask until taken.
//   clk, rst : clock, synchronous active-high reset
//   bus      : demux1to16_collect_if.slave (input bit stream, output word)
// Optional: DEMUX_DUPCHK_EN drops writes to already-written slots and
// raises a sticky dup_err; otherwise re-writes overwrite.
module demux1to16_collect
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned SEL_W = DEMUX_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  demux1to16_collect_if.slave   bus
);

  demux_state_e     state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, mask_q, mask_d;
  logic [WIDTH-1:0] out_q, out_d, out_mask_q, out_mask_d;
  logic [WIDTH-1:0] strobe, mask_nx, shadow_nx;
  logic             accept, wr_en;

  assign accept = bus.in_valid && (state_q == ST_FILL);

`ifdef DEMUX_DUPCHK_EN
  logic dup_q, dup_d, dup_hit;
  assign dup_hit     = accept && mask_q[bus.select];
  assign wr_en       = accept && !dup_hit;
  assign dup_d       = dup_q | dup_hit;
  assign bus.dup_err = dup_q;
`else
  assign wr_en = accept;
`endif

  demux1to16_dec #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dec (
    .sel_i    (bus.select),
    .en_i     (wr_en),
    .strobe_o (strobe)
  );

  // Assembly word including this cycle's write, so completion and flush
  // both see a same-cycle accept.
  assign mask_nx   = mask_q | strobe;
  assign shadow_nx = (shadow_q & ~strobe) | (bus.in_bit ? strobe : '0);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    mask_d     = mask_q;
    out_d      = out_q;
    out_mask_d = out_mask_q;
    case (state_q)
      ST_FILL: begin
        shadow_d = shadow_nx;
        mask_d   = mask_nx;
        if ((&mask_nx) || (bus.in_flush && (|mask_nx))) begin
          out_d      = shadow_nx;
          out_mask_d = mask_nx;
          shadow_d   = '0;
          mask_d     = '0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      shadow_q   <= '0;
      mask_q     <= '0;
      out_q      <= '0;
      out_mask_q <= '0;
`ifdef DEMUX_DUPCHK_EN
      dup_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      mask_q     <= mask_d;
      out_q      <= out_d;
      out_mask_q <= out_mask_d;
`ifdef DEMUX_DUPCHK_EN
      dup_q      <= dup_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out       = out_q;
  assign bus.out_mask  = out_mask_q;

endmodule

// File: tb/tb_demux1to16_collect.sv
// Testbench for demux1to16_collect: directed scenarios plus random traffic,
// expected words produced by a slot-array model and checked by a monitor.
module tb_demux1to16_collect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux1to16_collect_if #(.WIDTH(16), .SEL_W(4)) dif ();

  demux1to16_collect #(.WIDTH(16), .SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

`ifdef DEMUX_DUPCHK_EN
  localparam bit DUPCHK = 1'b1;
`else
  localparam bit DUPCHK = 1'b0;
`endif

  typedef struct {
    logic [15:0] word;
    logic [15:0] mask;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Reference model: per-slot data/written arrays, holding flag, sticky dup.
  bit m_data[16];
  bit m_written[16];
  bit m_hold;
  bit m_dup;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_data[i]    = 1'b0;
      m_written[i] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model for the coming edge,
  // then check the handshake outputs after that edge.
  task automatic step(input bit v, input bit b, input int unsigned sel,
                      input bit fl, input bit ordy, input bit r);
    int unsigned filled;
    exp_t        e;
    rst           = r;
    dif.in_valid  = v;
    dif.in_bit    = b;
    dif.select    = 4'(sel);
    dif.in_flush  = fl;
    dif.out_ready = ordy;
    if (r) begin
      model_clear();
      m_hold = 1'b0;
      m_dup  = 1'b0;
    end else if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else begin
      if (v) begin
        if (DUPCHK && m_written[sel]) m_dup = 1'b1;
        else begin
          m_data[sel]    = b;
          m_written[sel] = 1'b1;
        end
      end
      filled = 0;
      for (int i = 0; i < 16; i++) filled += m_written[i];
      if (filled == 16 || (fl && filled != 0)) begin
        for (int i = 0; i < 16; i++) begin
          e.word[i] = m_data[i];
          e.mask[i] = m_written[i];
        end
        sb.push_back(e);
        model_clear();
        m_hold = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("in_ready", dif.in_ready, !m_hold);
    chk("out_valid", dif.out_valid, m_hold);
`ifdef DEMUX_DUPCHK_EN
    chk("dup_err", dif.dup_err, m_dup);
`endif
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: pop on each new word, then require it stable while held.
  logic prev_v = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (!rst && dif.out_valid === 1'b1) begin
      if (!prev_v) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got out=%h mask=%h expected no word", dif.out, dif.out_mask);
          held.word = dif.out;
          held.mask = dif.out_mask;
        end else begin
          held = sb.pop_front();
          chk("out", dif.out, held.word);
          chk("out_mask", dif.out_mask, held.mask);
        end
      end else begin
        chk("out_stable", dif.out, held.word);
        chk("out_mask_stable", dif.out_mask, held.mask);
      end
    end
    prev_v = dif.out_valid;
  end

  logic [15:0] d;
  logic [15:0] tmp;

  initial begin
    dif.in_valid  = 1'b0;
    dif.in_bit    = 1'b0;
    dif.select    = '0;
    dif.in_flush  = 1'b0;
    dif.out_ready = 1'b0;
    model_clear();
    m_hold = 1'b0;
    m_dup  = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_out", dif.out, 16'h0000);
    chk("rst_out_mask", dif.out_mask, 16'h0000);

    // In-order fill
    d = 16'h3f0a;
    for (int i = 0; i < 16; i++) step(1, d[i], i, 0, 0, 0);
    chk("inorder_out", dif.out, 16'h3f0a);
    chk("inorder_mask", dif.out_mask, 16'hFFFF);
    idle(1'b1);

    // Reverse-order fill with gaps
    for (int i = 15; i >= 0; i--) begin
      step(1, d[i], i, 0, 0, 0);
      if (i != 0) begin
        idle(1'b0);
        idle(1'b0);
      end
    end
    chk("reverse_out", dif.out, 16'h3f0a);
    idle(1'b1);

    // Partial flush, then flush with empty mask
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("flush_out", dif.out, 16'h0002);
    chk("flush_mask", dif.out_mask, 16'h0012);
    idle(1'b1);
    step(0, 0, 0, 1, 0, 0);
    chk("empty_flush_valid", dif.out_valid, 1'b0);

    // Same-cycle accept and flush
    step(1, 1, 9, 0, 0, 0);
    step(1, 1, 3, 1, 0, 0);
    chk("acc_flush_out", dif.out, 16'h0208);
    idle(1'b1);

    // Backpressure with offers during HOLD
    d = 16'($urandom);
    for (int i = 0; i < 16; i++) step(1, d[i], i, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1'($urandom), $urandom_range(15), 0, 0, 0);
      chk("bp_out", dif.out, d);
    end
    idle(1'b1);

    // Duplicate write to slot 6
    step(1, 1, 6, 0, 0, 0);
    step(1, 0, 6, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    tmp = dif.out;
    chk("dup_bit6", tmp[6], DUPCHK);
    chk("dup_mask", dif.out_mask, 16'h0040);
    idle(1'b1);
`ifdef DEMUX_DUPCHK_EN
    chk("dup_err_sticky", dif.dup_err, 1'b1);
`endif

    // Reset mid-fill
    for (int i = 0; i < 5; i++) step(1, 1'($urandom), i, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    d = 16'hA5A5;
    for (int i = 0; i < 16; i++) step(1, d[i], i, 0, 0, 0);
    chk("post_rst_out", dif.out, 16'hA5A5);
    chk("post_rst_mask", dif.out_mask, 16'hFFFF);
    idle(1'b1);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(15),
           $urandom_range(0, 19) == 0, 1'($urandom), $urandom_range(0, 299) == 0);
    end

    idle(1'b1);
    idle(1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
